// File: rtl/whack_judge_pkg.sv
// rtl/whack_judge_pkg.sv - shared types, constants and saturating helpers for the whack-a-mole judge
package whack_pkg;

    localparam int NUM_HOLES = 5;
    localparam int POS_W     = 3;
    localparam logic [POS_W-1:0] NO_MOLE = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COOLDOWN
    } state_t;

    // Widths are passed as 32-bit values so the display logic can share these helpers.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] value);
        return (value == 32'd0) ? 32'd0 : value - 32'd1;
    endfunction

endpackage

// File: rtl/whack_judge_if.sv
// rtl/whack_judge_if.sv - game-side interface of the hit judge (buttons, mole position, score outputs)
interface whack_judge_if #(
    parameter int NUM_HOLES = 5,
    parameter int SCORE_W   = 8
);

    logic                       i_enable;
    logic                       i_clear;
    logic [whack_pkg::POS_W-1:0] i_mole_position;
    logic [NUM_HOLES-1:0]       i_btn;
    logic                       o_change_position;
    logic                       o_hit;
    logic [SCORE_W-1:0]         o_score;
    logic [SCORE_W-1:0]         o_miss;

    modport master (
        output i_enable, i_clear, i_mole_position, i_btn,
        input  o_change_position, o_hit, o_score, o_miss
    );

    modport slave (
        input  i_enable, i_clear, i_mole_position, i_btn,
        output o_change_position, o_hit, o_score, o_miss
    );

endinterface

// File: rtl/whack_judge_btn_edge_detect.sv
// rtl/whack_judge_btn_edge_detect.sv - registers button levels and reports rising edges per bit
module btn_edge_detect #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/whack_judge.sv
// rtl/whack_judge.sv - judges each button press as hit, wrong press or escape and keeps the score.
// Optional WHACK_MISS_PENALTY_EN: wrong presses also take one point off the score.
module whack_judge #(
    parameter int NUM_HOLES       = whack_pkg::NUM_HOLES,
    parameter int SCORE_W         = 8,
    parameter int COOLDOWN_CYCLES = 1000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    whack_judge_if.slave  bus
);

    import whack_pkg::*;

    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [31:0]      SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    state_t               state;
    logic [CNT_W-1:0]     cool_cnt;
    logic [POS_W-1:0]     pos_q;
    logic [NUM_HOLES-1:0] rise;
    logic [NUM_HOLES-1:0] hole_mask;
    logic                 judging;
    logic                 press;
    logic                 hit_ev;
    logic                 wrong_ev;
    logic                 escape_ev;

    btn_edge_detect #(
        .WIDTH (NUM_HOLES)
    ) u_edge (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (bus.i_btn),
        .rise  (rise)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_q <= NO_MOLE;
        end else begin
            pos_q <= bus.i_mole_position;
        end
    end

    // Judged against pos_q so a press races fairly with a simultaneous mole move.
    assign judging   = bus.i_enable && (state == ARMED) && (32'(pos_q) < NUM_HOLES);
    assign hole_mask = NUM_HOLES'(1) << pos_q;
    assign press     = |rise;
    assign hit_ev    = judging && (rise == hole_mask);
    assign wrong_ev  = judging && press && (rise != hole_mask);
    assign escape_ev = judging && !press && (bus.i_mole_position != pos_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                 <= IDLE;
            cool_cnt              <= '0;
            bus.o_change_position <= 1'b0;
            bus.o_hit             <= 1'b0;
            bus.o_score           <= '0;
            bus.o_miss            <= '0;
        end else begin
            bus.o_change_position <= 1'b0;
            bus.o_hit             <= 1'b0;

            if (!bus.i_enable) begin
                state    <= IDLE;
                cool_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    ARMED: begin
                        if (hit_ev) begin
                            state                 <= COOLDOWN;
                            cool_cnt              <= CNT_LOAD;
                            bus.o_change_position <= 1'b1;
                            bus.o_hit             <= 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        if (cool_cnt == '0) begin
                            state <= ARMED;
                        end else begin
                            cool_cnt <= cool_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cool_cnt <= '0;
                    end
                endcase
            end

            if (bus.i_clear) begin
                bus.o_score <= '0;
                bus.o_miss  <= '0;
            end else begin
                if (hit_ev) begin
                    bus.o_score <= SCORE_W'(sat_inc(32'(bus.o_score), SCORE_MAX));
                end
                if (wrong_ev || escape_ev) begin
                    bus.o_miss <= SCORE_W'(sat_inc(32'(bus.o_miss), SCORE_MAX));
                end
`ifdef WHACK_MISS_PENALTY_EN
                if (wrong_ev) begin
                    bus.o_score <= SCORE_W'(sat_dec(32'(bus.o_score)));
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_whack_judge.sv
// tb/tb_whack_judge.sv - directed self-checking bench for whack_judge
module tb_whack_judge;

`ifdef WHACK_MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hit_seen;

    always #5 clk = ~clk;

    whack_judge_if #(.NUM_HOLES(5), .SCORE_W(8)) bus ();

    whack_judge #(
        .NUM_HOLES       (5),
        .SCORE_W         (8),
        .COOLDOWN_CYCLES (1000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Moves the mole while disabled (no escape), then re-arms with no button held.
    task automatic set_pos_idle(input logic [2:0] p);
        bus.i_enable        = 1'b0;
        bus.i_mole_position = p;
        bus.i_btn           = '0;
        step();
        bus.i_enable = 1'b1;
        step();
    endtask

    task automatic hit_once(input logic [2:0] p);
        bus.i_btn = 5'(1) << p;
        step();
        set_pos_idle(p);
    endtask

    initial begin
        bus.i_enable        = 1'b0;
        bus.i_clear         = 1'b0;
        bus.i_mole_position = 3'd5;
        bus.i_btn           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_change", 32'(bus.o_change_position), 0);
        check("rst_hit",    32'(bus.o_hit), 0);
        check("rst_score",  32'(bus.o_score), 0);
        check("rst_miss",   32'(bus.o_miss), 0);
        rst = 1'b0;

        bus.i_enable        = 1'b1;
        bus.i_mole_position = 3'd2;
        step();
        step();
        bus.i_btn = 5'b00100;
        step();
        check("hit1_change", 32'(bus.o_change_position), 1);
        check("hit1_hit",    32'(bus.o_hit), 1);
        check("hit1_score",  32'(bus.o_score), 1);
        check("hit1_miss",   32'(bus.o_miss), 0);
        bus.i_btn = '0;
        step();
        check("hit1_pulse_end", 32'(bus.o_change_position), 0);

        // Cooldown edges 2..1000 with presses on even edges; edge 1000 is the last ignored one.
        hit_seen = 0;
        for (int e = 2; e <= 1000; e++) begin
            bus.i_btn = (e % 2 == 0) ? 5'b00100 : 5'b00000;
            step();
            if (bus.o_hit || bus.o_change_position) hit_seen++;
        end
        check("cool1_ignored", 32'(hit_seen), 0);
        check("cool1_score",   32'(bus.o_score), 1);
        bus.i_btn = '0;
        step();
        bus.i_btn = 5'b00100;
        step();
        check("hit2_hit",   32'(bus.o_hit), 1);
        check("hit2_score", 32'(bus.o_score), 2);

        // Second cooldown: quiet for 1000 edges, then the very first judged edge must hit.
        bus.i_btn = '0;
        hit_seen  = 0;
        for (int e = 1; e <= 1000; e++) begin
            step();
            if (bus.o_hit || bus.o_change_position) hit_seen++;
        end
        check("cool2_ignored", 32'(hit_seen), 0);
        bus.i_btn = 5'b00100;
        step();
        check("hit3_earliest", 32'(bus.o_hit), 1);
        check("hit3_score",    32'(bus.o_score), 3);

        set_pos_idle(3'd3);
        bus.i_btn = 5'b00010;
        step();
        check("wrong_miss",   32'(bus.o_miss), 1);
        check("wrong_score",  32'(bus.o_score), 32'(3 - PEN));
        check("wrong_change", 32'(bus.o_change_position), 0);

        set_pos_idle(3'd0);
        bus.i_btn = 5'b10001;
        step();
        check("multi_miss",   32'(bus.o_miss), 2);
        check("multi_score",  32'(bus.o_score), 32'(3 - 2 * PEN));
        check("multi_change", 32'(bus.o_change_position), 0);

        set_pos_idle(3'd5);
        bus.i_btn = 5'b00100;
        step();
        check("nomole_miss",   32'(bus.o_miss), 2);
        check("nomole_score",  32'(bus.o_score), 32'(3 - 2 * PEN));
        check("nomole_change", 32'(bus.o_change_position), 0);

        set_pos_idle(3'd1);
        bus.i_mole_position = 3'd4;
        step();
        check("escape_miss",   32'(bus.o_miss), 3);
        check("escape_change", 32'(bus.o_change_position), 0);

        set_pos_idle(3'd1);
        bus.i_mole_position = 3'd4;
        bus.i_btn           = 5'b00010;
        step();
        check("esc_hit_hit",   32'(bus.o_hit), 1);
        check("esc_hit_miss",  32'(bus.o_miss), 3);
        check("esc_hit_score", 32'(bus.o_score), 32'(4 - 2 * PEN));

        set_pos_idle(3'd2);
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        check("clear_score", 32'(bus.o_score), 0);
        check("clear_miss",  32'(bus.o_miss), 0);
        bus.i_btn = 5'b00001;
        step();
        check("wrong_at0_score", 32'(bus.o_score), 0);
        check("wrong_at0_miss",  32'(bus.o_miss), 1);

        set_pos_idle(3'd2);
        for (int i = 0; i < 255; i++) hit_once(3'd2);
        check("sat_reach", 32'(bus.o_score), 255);
        bus.i_btn = 5'b00100;
        step();
        check("sat_change", 32'(bus.o_change_position), 1);
        check("sat_score",  32'(bus.o_score), 255);

        set_pos_idle(3'd2);
        bus.i_clear = 1'b1;
        bus.i_btn   = 5'b00100;
        step();
        bus.i_clear = 1'b0;
        check("clrhit_score", 32'(bus.o_score), 0);
        check("clrhit_miss",  32'(bus.o_miss), 0);
        check("clrhit_hit",   32'(bus.o_hit), 1);

        set_pos_idle(3'd2);
        bus.i_btn = 5'b00001;
        step();
        set_pos_idle(3'd2);
        bus.i_btn = 5'b00100;
        step();
        check("pre_rst_score",  32'(bus.o_score), 1);
        check("pre_rst_miss",   32'(bus.o_miss), 1);
        check("pre_rst_change", 32'(bus.o_change_position), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_change", 32'(bus.o_change_position), 0);
        check("async_rst_hit",    32'(bus.o_hit), 0);
        check("async_rst_score",  32'(bus.o_score), 0);
        check("async_rst_miss",   32'(bus.o_miss), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
